// File: rtl/bicubic_tap_sequencer_if.sv
// Pixel stream, tap/table bus and output stream between the window fetch,
// the shared bicubic weight tables and the output pixel writer.
interface bicubic_tap_sequencer_if #(
  parameter int DW = 8,
  parameter int SW = 15
);
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [1:0]    h_phase;
  logic [1:0]    v_phase;
  logic [DW-1:0] tap_0;
  logic [DW-1:0] tap_1;
  logic [DW-1:0] tap_2;
  logic [DW-1:0] tap_3;
  logic [1:0]    tbl_sel;
  logic          tap_valid;
  logic [SW-1:0] weight_sum;
  logic [DW-1:0] out_pix;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport slave (
    input  pix_in, pix_valid, h_phase, v_phase, weight_sum, out_ready,
    output pix_ready, tap_0, tap_1, tap_2, tap_3, tbl_sel, tap_valid,
           out_pix, out_valid, busy
  );

  modport master (
    output pix_in, pix_valid, h_phase, v_phase, weight_sum, out_ready,
    input  pix_ready, tap_0, tap_1, tap_2, tap_3, tbl_sel, tap_valid,
           out_pix, out_valid, busy
  );
endinterface

// File: rtl/bicubic_tap_sequencer.sv
// Sequences a 4x4 window through the shared 4-tap weight tables: four
// horizontal row passes, one vertical pass, one output pixel per window.
//
// state | meaning
// IDLE  | waiting for p0, latches h/v phase with it
// LOAD  | collecting p1..p15
// HPASS | rows issued one per cycle, h[k] captured LAT cycles later
// VPASS | h[0..3] issued once, result captured LAT cycles later
// OUT   | out_pix held until out_ready
module bicubic_tap_sequencer #(
  parameter int DW   = 8,
  parameter int SW   = 15,
  parameter int FRAC = 7,
  parameter int LAT  = 1
) (
  input logic                    clk,
  input logic                    rst,
  bicubic_tap_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HPASS = 3'd2;
  localparam logic [2:0] S_VPASS = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [3:0] LAT_C  = 4'(LAT);
  localparam logic [3:0] H_LAST = 4'(3 + LAT);
  localparam logic [SW:0] RND   = (SW+1)'(1) << (FRAC - 1);
  localparam logic [SW:0] PMAX  = (SW+1)'((1 << DW) - 1);

  // One extra bit so the rounding add can never wrap before the clamp.
  function automatic logic [DW-1:0] sat(input logic [SW-1:0] x);
    logic [SW:0] r;
    r = ({1'b0, x} + RND) >> FRAC;
    return (r > PMAX) ? {DW{1'b1}} : r[DW-1:0];
  endfunction

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [DW-1:0] pix_q [16];
  logic [DW-1:0] h_q [4];
  logic [1:0]    hph_q, vph_q;
  logic [DW-1:0] out_pix_q;
  logic          out_valid_q;

  logic          pix_ready;
  logic          pix_acc;
  logic [1:0]    hidx;
  logic [DW-1:0] tap_c [4];
  logic          tap_valid_c;
  logic [1:0]    tbl_sel_c;

  assign pix_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign pix_acc   = bus.pix_valid && pix_ready;
  assign hidx      = 2'(cyc_q - LAT_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (pix_acc) begin
          state_d = S_LOAD;
          cnt_d   = 4'd1;
        end
      end
      S_LOAD: begin
        if (pix_acc) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_HPASS;
            cnt_d   = 4'd0;
            cyc_d   = 4'd0;
          end
        end
      end
      S_HPASS: begin
        cyc_d = cyc_q + 4'd1;
        if (cyc_q == H_LAST) begin
          state_d = S_VPASS;
          cyc_d   = 4'd0;
        end
      end
      S_VPASS: begin
        cyc_d = cyc_q + 4'd1;
        if (cyc_q == LAT_C) begin
          state_d = S_OUT;
          cyc_d   = 4'd0;
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 4; j++) tap_c[j] = '0;
    tap_valid_c = 1'b0;
    tbl_sel_c   = 2'd0;
    case (state_q)
      S_HPASS: begin
        tbl_sel_c = hph_q;
        if (cyc_q < 4'd4) begin
          tap_valid_c = 1'b1;
          for (int j = 0; j < 4; j++) tap_c[j] = pix_q[{cyc_q[1:0], 2'(j)}];
        end
      end
      S_VPASS: begin
        tbl_sel_c = vph_q;
        if (cyc_q == 4'd0) begin
          tap_valid_c = 1'b1;
          for (int j = 0; j < 4; j++) tap_c[j] = h_q[j];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cyc_q       <= '0;
      hph_q       <= '0;
      vph_q       <= '0;
      out_pix_q   <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) pix_q[i] <= '0;
      for (int i = 0; i < 4; i++) h_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      if (pix_acc) pix_q[cnt_q] <= bus.pix_in;
      if (state_q == S_IDLE && pix_acc) begin
        hph_q <= bus.h_phase;
        vph_q <= bus.v_phase;
      end
      if (state_q == S_HPASS && cyc_q >= LAT_C) h_q[hidx] <= sat(bus.weight_sum);
      if (state_q == S_VPASS && cyc_q == LAT_C) begin
        out_pix_q   <= sat(bus.weight_sum);
        out_valid_q <= 1'b1;
      end
      if (state_q == S_OUT && bus.out_ready) out_valid_q <= 1'b0;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.tap_0     = tap_c[0];
  assign bus.tap_1     = tap_c[1];
  assign bus.tap_2     = tap_c[2];
  assign bus.tap_3     = tap_c[3];
  assign bus.tap_valid = tap_valid_c;
  assign bus.tbl_sel   = tbl_sel_c;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_bicubic_tap_sequencer.sv
// Scoreboard bench: a registered 4-table weight model drives weight_sum,
// stimulus pushes expected pixels, a monitor pops them on each out_valid rise.
module tb_bicubic_tap_sequencer;
  localparam int DW = 8;
  localparam int SW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bicubic_tap_sequencer_if #(.DW(DW), .SW(SW)) bus ();

  bicubic_tap_sequencer #(.DW(DW), .SW(SW), .FRAC(7), .LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int coef [4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3},
                      '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};

  function automatic int ref_pass(input logic [1:0] t, input int a, b, c, d);
    int s;
    s = coef[t][0]*a + coef[t][1]*b + coef[t][2]*c + coef[t][3]*d;
    if (s < 0) s = 0;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  function automatic int sat_ref(input int x);
    int y;
    y = (x + 64) / 128;
    return (y > 255) ? 255 : y;
  endfunction

  function automatic int ref_window(input int p [16], input logic [1:0] hp, vp);
    int h [4];
    for (int r = 0; r < 4; r++)
      h[r] = sat_ref(ref_pass(hp, p[4*r], p[4*r+1], p[4*r+2], p[4*r+3]));
    return sat_ref(ref_pass(vp, h[0], h[1], h[2], h[3]));
  endfunction

  // External table model: one register stage, optional forced result.
  int            ws_mode;
  logic [SW-1:0] ws_const;
  always @(posedge clk)
    bus.weight_sum <= (ws_mode != 0) ? ws_const :
                      SW'(ref_pass(bus.tbl_sel, bus.tap_0, bus.tap_1, bus.tap_2, bus.tap_3));

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  typedef struct {int pix; int acc;} exp_t;
  exp_t sb [$];
  int   rise_q [$];

  logic prev_ov = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) prev_ov = 1'b0;
    else begin
      if (bus.out_valid && !prev_ov) begin
        rise_q.push_back(cyc);
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_out: got %0h expected none", bus.out_pix);
        end else begin
          e = sb.pop_front();
          chk("out_pix", bus.out_pix, e.pix);
          chk("latency", cyc - e.acc, 7);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, bus.pix_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_pix"},   bus.out_pix, 0);
    chk({tag, "_taps"},      int'({bus.tap_0, bus.tap_1, bus.tap_2, bus.tap_3}), 0);
    chk({tag, "_tbl_sel"},   bus.tbl_sel, 0);
    chk({tag, "_tap_valid"}, bus.tap_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
  endtask

  // Entered just after a negedge; returns at the negedge after acceptance.
  task automatic drive_pix(input int v, output int acc_cyc);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    bus.pix_in    = DW'(v);
    bus.pix_valid = 1'b1;
    while (!done) begin
      #1;
      done = bus.pix_ready;
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        $display("FAIL pix_accept: got no pix_ready expected acceptance");
        $fatal(1, "stuck");
      end
    end
    bus.pix_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic load_window(input int p [16], input logic [1:0] hp, vp,
                             input bit gap, input bit chg, output int acc15);
    int a;
    for (int i = 0; i < 16; i++) begin
      if (gap && i > 0) begin
        bus.pix_valid = 1'b0;
        @(negedge clk);
      end
      if (i == 0) begin
        bus.h_phase = hp;
        bus.v_phase = vp;
      end
      drive_pix(p[i], a);
      if (i == 0 && chg) begin
        bus.h_phase = ~hp;
        bus.v_phase = ~vp;
      end
    end
    acc15 = a;
  endtask

  task automatic check_passes(input int p [16], input logic [1:0] hp, vp);
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("tap_row", int'({bus.tap_0, bus.tap_1, bus.tap_2, bus.tap_3}),
          (p[4*r] << 24) | (p[4*r+1] << 16) | (p[4*r+2] << 8) | p[4*r+3]);
      chk("tap_valid_h", bus.tap_valid, 1);
      chk("tbl_sel_h", bus.tbl_sel, hp);
      @(negedge clk);
    end
    #1;
    chk("tap_valid_tail", bus.tap_valid, 0);
    chk("taps_tail", int'({bus.tap_0, bus.tap_1, bus.tap_2, bus.tap_3}), 0);
    @(negedge clk);
    #1;
    chk("tbl_sel_v", bus.tbl_sel, vp);
    chk("tap_valid_v", bus.tap_valid, 1);
  endtask

  task automatic run_window(input int p [16], input logic [1:0] hp, vp,
                            input bit gap, input bit chg, input int exp_pix);
    int a;
    load_window(p, hp, vp, gap, chg, a);
    sb.push_back('{pix: exp_pix, acc: a});
    check_passes(p, hp, vp);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      #3;
      g++;
    end
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  int winA [16], winB [16], winC [16], winD [16], winE [16], winF [16];

  initial begin
    int g, r0, expB;
    winA = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25};
    winB = '{50, 60, 70, 80, 90, 100, 110, 120, 30, 40, 50, 60, 200, 210, 220, 230};
    winC = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 7, 8};
    winD = '{100, 90, 80, 70, 60, 50, 40, 30, 20, 10, 0, 10, 20, 30, 40, 50};
    winE = '{10, 20, 30, 40, 40, 30, 20, 10, 0, 255, 255, 0, 128, 128, 128, 128};
    winF = '{255, 0, 0, 255, 1, 2, 3, 4, 200, 100, 50, 25, 7, 77, 177, 250};
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.h_phase = '0; bus.v_phase = '0;
    bus.out_ready = 1'b1; ws_mode = 0; ws_const = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table 0 passes in_1 through: result is p5.
    run_window(winA, 2'd0, 2'd0, 1'b0, 1'b0, 15);
    wait_drain();

    ws_mode = 1;
    ws_const = 15'h7FFF;
    run_window(winA, 2'd0, 2'd0, 1'b0, 1'b0, 255);
    wait_drain();
    ws_const = 15'd63;
    run_window(winA, 2'd0, 2'd0, 1'b0, 1'b0, 0);
    wait_drain();
    ws_const = 15'd64;
    run_window(winA, 2'd0, 2'd0, 1'b0, 1'b0, 1);
    wait_drain();
    ws_mode = 0;

    // Gapped load with phases flipped after p0.
    run_window(winA, 2'd0, 2'd0, 1'b1, 1'b1, 15);
    wait_drain();

    // Output back-pressure.
    bus.out_ready = 1'b0;
    expB = ref_window(winB, 2'd2, 2'd1);
    run_window(winB, 2'd2, 2'd1, 1'b0, 1'b0, expB);
    g = 0;
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.out_valid) begin
      n_tot++;
      $display("FAIL out_valid_wait: got 0 expected 1");
    end
    for (int k = 0; k < 10; k++) begin
      bus.pix_valid = k[0];
      bus.pix_in = DW'(k);
      @(negedge clk);
      #1;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_pix", bus.out_pix, expB);
      chk("hold_pix_ready", bus.pix_ready, 0);
    end
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_busy", bus.busy, 0);
    chk("release_pix_ready", bus.pix_ready, 1);

    // Reset while row 2 is on the taps.
    begin
      int a;
      load_window(winC, 2'd1, 2'd1, 1'b0, 1'b0, a);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    run_window(winD, 2'd2, 2'd2, 1'b0, 1'b0, ref_window(winD, 2'd2, 2'd2));
    wait_drain();

    // Back-to-back windows.
    r0 = rise_q.size();
    run_window(winE, 2'd1, 2'd3, 1'b0, 1'b0, ref_window(winE, 2'd1, 2'd3));
    run_window(winF, 2'd1, 2'd3, 1'b0, 1'b0, ref_window(winF, 2'd1, 2'd3));
    wait_drain();
    if (rise_q.size() >= r0 + 2) chk("b2b_spacing", rise_q[r0+1] - rise_q[r0], 24);
    else begin
      n_tot++;
      $display("FAIL b2b_spacing: got %0d rises expected 2", rise_q.size() - r0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
